// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled start/data/stop detection with a valid/ready
// output register and single-cycle framing-error / overrun pulses.
module uart_receiver #(
  parameter int OVERSAMPLE   = 16,
  parameter int SAMPLE_POINT = 8
) (
  input  logic       uart_samplig_clk,
  input  logic       reset_n,
  input  logic       RsRx,
  output logic [7:0] data_received,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] START_LAST_C = CW'(SAMPLE_POINT - 1);
  localparam logic [CW-1:0] BIT_LAST_C   = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [1:0]      sync_r;
  logic            rx_s;
  logic [CW-1:0]   clk_cnt_r;
  logic [2:0]      bit_idx_r;
  logic [7:0]      shreg_r;
  logic [7:0]      data_r;
  logic            valid_r;
  logic            frame_err_r;
  logic            overrun_r;
  logic            sample_bit_s;
  logic            stop_ok_s;
  logic            stop_bad_s;
  logic            load_s;
  logic            drop_s;

  assign rx_s          = sync_r[1];
  assign data_received = data_r;
  assign valid         = valid_r;
  assign frame_err     = frame_err_r;
  assign overrun       = overrun_r;

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge uart_samplig_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], RsRx};
    end
  end

  // State register and tick counter; the counter restarts on every state change.
  always_ff @(posedge uart_samplig_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= S_IDLE;
      clk_cnt_r <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      if (state_s != state_r) begin
        clk_cnt_r <= {CW{1'b0}};
      end else begin
        clk_cnt_r <= clk_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Next-state decode; the stop bit is judged mid-bit so a following start bit is not missed.
  always_comb begin
    state_s      = state_r;
    sample_bit_s = 1'b0;
    stop_ok_s    = 1'b0;
    stop_bad_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!rx_s) state_s = S_START;
        else       state_s = S_IDLE;
      end
      S_START: begin
        if (clk_cnt_r == START_LAST_C) begin
          if (rx_s) state_s = S_IDLE;
          else      state_s = S_DATA;
        end else begin
          state_s = S_START;
        end
      end
      S_DATA: begin
        if (clk_cnt_r == BIT_LAST_C) begin
          sample_bit_s = 1'b1;
          if (bit_idx_r == 3'd7) state_s = S_STOP;
          else                   state_s = S_DATA;
        end else begin
          state_s = S_DATA;
        end
      end
      S_STOP: begin
        if (clk_cnt_r == BIT_LAST_C) begin
          if (rx_s) begin
            stop_ok_s = 1'b1;
            state_s   = S_IDLE;
          end else begin
            stop_bad_s = 1'b1;
            state_s    = S_BREAK;
          end
        end else begin
          state_s = S_STOP;
        end
      end
      S_BREAK: begin
        if (rx_s) state_s = S_IDLE;
        else      state_s = S_BREAK;
      end
      default: state_s = S_IDLE;
    endcase
  end

  assign load_s = stop_ok_s && (!valid_r || ready);
  assign drop_s = stop_ok_s && valid_r && !ready;

  // Shift register collects data bits LSB first.
  always_ff @(posedge uart_samplig_clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_idx_r <= 3'd0;
      shreg_r   <= 8'h00;
    end else if ((state_r == S_START) && (state_s == S_DATA)) begin
      bit_idx_r <= 3'd0;
    end else if (sample_bit_s) begin
      shreg_r   <= {rx_s, shreg_r[7:1]};
      bit_idx_r <= bit_idx_r + 3'd1;
    end
  end

  // Output holding register, handshake and event pulses.
  always_ff @(posedge uart_samplig_clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r      <= 8'h00;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= stop_bad_s;
      overrun_r   <= drop_s;
      if (load_s) begin
        data_r  <= shreg_r;
        valid_r <= 1'b1;
      end else if (valid_r && ready) begin
        valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: a serial driver pushes expected bytes,
// a negedge monitor pops them on each valid&&ready transfer and tallies flag pulses.
module tb_uart_receiver;

  logic       clk;
  logic       reset_n;
  logic       rs_rx;
  logic [7:0] data_received;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  int n_checks;
  int n_fail;
  int fe_cnt;
  int ov_cnt;
  int exp_fe;
  int exp_ov;
  logic [7:0] sb[$];
  logic       rand_mode;
  logic       ready_fixed;
  logic       prev_hold;
  logic [7:0] prev_data;

  uart_receiver #(.OVERSAMPLE(16), .SAMPLE_POINT(8)) dut (
    .uart_samplig_clk(clk),
    .reset_n(reset_n),
    .RsRx(rs_rx),
    .data_received(data_received),
    .valid(valid),
    .ready(ready),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Serial frame: start, 8 data bits LSB first, one stop bit of the given level.
  task automatic send(input logic [7:0] b, input logic stop);
    rs_rx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rs_rx = b[i];
      tick(16);
    end
    rs_rx = stop;
    tick(16);
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while ((sb.size() != 0) && (c < budget)) begin
      tick(1);
      c++;
    end
    chk("drain", sb.size(), 0);
  endtask

  // Consumer: ready either fixed or random, changed only just after a rising edge.
  always @(posedge clk) begin
    #1;
    if (rand_mode) ready = 1'($urandom_range(0, 1));
    else           ready = ready_fixed;
  end

  // Monitor: transfers, hold stability and flag pulse counting.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_hold = 1'b0;
    end else begin
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      if (frame_err || overrun) chk("flags_exclusive", {31'd0, frame_err & overrun}, 32'd0);
      if (prev_hold) begin
        chk("hold_valid", {31'd0, valid}, 32'd1);
        chk("hold_data", {24'd0, data_received}, {24'd0, prev_data});
      end
      if (valid && ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_byte", {24'd0, data_received}, 32'hFFFF_FFFF);
        end else begin
          chk("rx_byte", {24'd0, data_received}, {24'd0, sb.pop_front()});
        end
      end
      prev_hold = valid && !ready;
      prev_data = data_received;
    end
  end

  initial begin
    logic [7:0] b;
    n_checks = 0; n_fail = 0; fe_cnt = 0; ov_cnt = 0; exp_fe = 0; exp_ov = 0;
    rand_mode = 1'b0; ready_fixed = 1'b0; ready = 1'b0; prev_hold = 1'b0; prev_data = 8'h00;
    rs_rx = 1'b1;
    reset_n = 1'b0;
    tick(3);
    chk("reset_data", {24'd0, data_received}, 32'h00);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_overrun", {31'd0, overrun}, 32'd0);
    reset_n = 1'b1;
    tick(10);

    // Plain frame with ready high
    ready_fixed = 1'b1;
    tick(2);
    sb.push_back(8'hA5);
    send(8'hA5, 1'b1);
    tick(10);
    wait_drain(100);
    chk("t1_valid_dropped", {31'd0, valid}, 32'd0);

    // Short glitch on the line, then a good frame
    rs_rx = 1'b0;
    tick(4);
    rs_rx = 1'b1;
    tick(40);
    chk("t2_no_valid", {31'd0, valid}, 32'd0);
    chk("t2_no_frame_err", fe_cnt, 0);
    sb.push_back(8'h3C);
    send(8'h3C, 1'b1);
    tick(10);
    wait_drain(100);

    // Bad stop bit followed by a held-low line
    send(8'hFF, 1'b0);
    tick(40);
    exp_fe++;
    chk("t3_frame_err_count", fe_cnt, exp_fe);
    chk("t3_no_valid", {31'd0, valid}, 32'd0);
    rs_rx = 1'b1;
    tick(40);
    sb.push_back(8'h01);
    send(8'h01, 1'b1);
    tick(10);
    wait_drain(100);

    // Overrun: two back-to-back frames while the consumer stalls
    ready_fixed = 1'b0;
    tick(2);
    sb.push_back(8'h11);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    tick(20);
    exp_ov++;
    chk("t4_valid_held", {31'd0, valid}, 32'd1);
    chk("t4_data_held", {24'd0, data_received}, 32'h11);
    chk("t4_overrun_count", ov_cnt, exp_ov);
    ready_fixed = 1'b1;
    wait_drain(20);
    tick(3);
    chk("t4_valid_dropped", {31'd0, valid}, 32'd0);

    // Reset in the middle of a frame while a byte is pending
    ready_fixed = 1'b0;
    tick(2);
    send(8'h77, 1'b1);
    tick(10);
    chk("t5_pending_valid", {31'd0, valid}, 32'd1);
    rs_rx = 1'b0;
    tick(16);
    for (int i = 0; i < 3; i++) begin
      rs_rx = i[0];
      tick(16);
    end
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t5_reset_data", {24'd0, data_received}, 32'h00);
    chk("t5_reset_valid", {31'd0, valid}, 32'd0);
    chk("t5_reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("t5_reset_overrun", {31'd0, overrun}, 32'd0);
    sb.delete();
    tick(3);
    rs_rx = 1'b1;
    tick(2);
    reset_n = 1'b1;
    ready_fixed = 1'b1;
    tick(20);
    sb.push_back(8'hC3);
    send(8'hC3, 1'b1);
    tick(10);
    wait_drain(100);

    // Random bytes with a randomly stalling consumer, paced to avoid overrun
    rand_mode = 1'b1;
    for (int k = 0; k < 256; k++) begin
      b = 8'($urandom_range(0, 255));
      sb.push_back(b);
      send(b, 1'b1);
      wait_drain(200);
    end
    rand_mode = 1'b0;
    tick(20);

    chk("final_frame_err_count", fe_cnt, exp_fe);
    chk("final_overrun_count", ov_cnt, exp_ov);
    chk("final_valid", {31'd0, valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
